// File: rtl/asca16_dmem_pkg.sv
// asca16_dmem_pkg: shared constants for the data-memory responder and its timer.
package asca16_dmem_pkg;
   localparam int DATA_W = 16;
   localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
   localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
   localparam logic [2:0] OFF_TCNT     = 3'd2;
   localparam logic [2:0] OFF_TCMP     = 3'd3;
   localparam logic [2:0] OFF_TCTRL    = 3'd4;
   localparam int TCTRL_EN     = 0;
   localparam int TCTRL_RELOAD = 1;
   localparam int TCTRL_MATCH  = 2;
   localparam logic [DATA_W-1:0] TCMP_RST = 16'hFFFF;
   typedef enum logic [1:0] {REGION_RAM, REGION_MMIO, REGION_NONE} region_e;
endpackage

// File: rtl/asca16_timer.sv
// asca16_timer: free-running/reloading counter with compare, sticky MATCH flag and one-cycle irq.
module asca16_timer
   import asca16_dmem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cnt_wr,
   input  logic              cmp_wr,
   input  logic              ctrl_wr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] cnt,
   output logic [DATA_W-1:0] cmp,
   output logic [2:0]        ctrl,
   output logic              irq
);
   logic en, reload, match_flag, hit;
   logic [DATA_W-1:0] cnt_nxt;
   assign hit  = en && cnt == cmp;
   assign ctrl = {match_flag, reload, en};
   // CPU write wins over increment/reload
   always_comb cnt_nxt = cnt_wr ? wdata : !en ? cnt : (hit && reload) ? '0 : cnt + 1'b1;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt        <= '0;
         cmp        <= TCMP_RST;
         en         <= 1'b0;
         reload     <= 1'b0;
         match_flag <= 1'b0;
         irq        <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (cmp_wr) cmp <= wdata;
         if (ctrl_wr) begin
            en     <= wdata[TCTRL_EN];
            reload <= wdata[TCTRL_RELOAD];
         end
         match_flag <= hit | (match_flag & ~(ctrl_wr & wdata[TCTRL_MATCH]));
         irq        <= hit;
      end
endmodule

// File: rtl/asca16_dmem.sv
// asca16_dmem: word RAM plus GPIO/timer MMIO window on the core's ram_* port.
// Timer present only when ASCA_DMEM_TIMER_EN is defined.
module asca16_dmem
   import asca16_dmem_pkg::*;
#(
   parameter int              DEPTH     = 1024,
   parameter int              AW        = 10,
   parameter logic [15:0]     MMIO_BASE = 16'hFF00,
   parameter int              GPIO_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ram_wen,
   input  logic [15:0]       ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] ram_in,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [GPIO_W-1:0] gpio_s1, gpio_s2;
   logic [DATA_W-1:0] tcnt, tcmp, mmio_rd;
   logic [2:0]        tctrl, off;
   region_e           region;
   logic              mmio_wr;
   assign off     = ram_addr[2:0];
   assign region  = ram_addr[15:AW] == '0 ? REGION_RAM :
                    ram_addr[15:3] == MMIO_BASE[15:3] ? REGION_MMIO : REGION_NONE;
   assign mmio_wr = ram_wen && region == REGION_MMIO;
   // Stores arriving while reset is held are dropped
   always_ff @(posedge clk)
      if (ram_wen && region == REGION_RAM && !reset) mem[ram_addr[AW-1:0]] <= ram_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         gpio_out <= '0;
         gpio_s1  <= '0;
         gpio_s2  <= '0;
      end else begin
         if (mmio_wr && off == OFF_GPIO_OUT) gpio_out <= ram_data[GPIO_W-1:0];
         gpio_s1 <= gpio_in;
         gpio_s2 <= gpio_s1;
      end
`ifdef ASCA_DMEM_TIMER_EN
   asca16_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .cnt_wr  (mmio_wr && off == OFF_TCNT),
      .cmp_wr  (mmio_wr && off == OFF_TCMP),
      .ctrl_wr (mmio_wr && off == OFF_TCTRL),
      .wdata   (ram_data),
      .cnt     (tcnt),
      .cmp     (tcmp),
      .ctrl    (tctrl),
      .irq     (irq)
   );
`else
   assign tcnt  = '0;
   assign tcmp  = '0;
   assign tctrl = '0;
   assign irq   = 1'b0;
`endif
   always_comb begin
      mmio_rd = off == OFF_GPIO_OUT ? DATA_W'(gpio_out) :
                off == OFF_GPIO_IN  ? DATA_W'(gpio_s2)  :
                off == OFF_TCNT     ? tcnt              :
                off == OFF_TCMP     ? tcmp              :
                off == OFF_TCTRL    ? DATA_W'(tctrl)    : '0;
      ram_in  = region == REGION_RAM  ? mem[ram_addr[AW-1:0]] :
                region == REGION_MMIO ? mmio_rd : '0;
   end
endmodule

// File: tb/tb_asca16_dmem.sv
// tb_asca16_dmem: randomized self-checking bench for asca16_dmem against an array/arithmetic model.
module tb_asca16_dmem;
   logic        clk = 1'b0;
   logic        reset, ram_wen, irq;
   logic [15:0] ram_addr, ram_data, ram_in;
   logic [7:0]  gpio_in, gpio_out;
   int          tests = 0, fails = 0;
   logic [15:0] model_mem [1024];
   int          written [$];
`ifdef ASCA_DMEM_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   always #5 clk = ~clk;

   asca16_dmem dut (
      .clk      (clk),
      .reset    (reset),
      .ram_wen  (ram_wen),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .ram_in   (ram_in),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq      (irq)
   );

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      ram_wen = 1'b1; ram_addr = a; ram_data = d;
      @(posedge clk); #1;
      ram_wen = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      ram_addr = a; #1; v = ram_in;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      logic [15:0] exp_cmp;
      exp_cmp = TIMER ? 16'hFFFF : 16'h0000;
      tests++; if (gpio_out !== 8'h00) begin fails++; $display("FAIL reset_gpio_out: got %h want 00", gpio_out); end
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
      for (int o = 0; o < 8; o++) begin
         rd(16'hFF00 + 16'(o), v);
         tests++;
         if (v !== (o == 3 ? exp_cmp : 16'h0000)) begin
            fails++; $display("FAIL reset_mmio%0d: got %h want %h", o, v, (o == 3 ? exp_cmp : 16'h0000));
         end
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ram;
      logic [15:0] v, a, d;
      wr(16'h0010, 16'hBEEF); model_mem[16] = 16'hBEEF;
      wr(16'h0020, 16'h1111); model_mem[32] = 16'h1111;
      rd(16'h0010, v);
      tests++; if (v !== 16'hBEEF) begin fails++; $display("FAIL ram_beef: got %h want beef", v); end
      ram_wen = 1'b1; ram_addr = 16'h0010; ram_data = 16'h1234; #1;
      tests++; if (ram_in !== 16'hBEEF) begin fails++; $display("FAIL ram_same_cycle: got %h want beef", ram_in); end
      @(posedge clk); #1; ram_wen = 1'b0; model_mem[16] = 16'h1234;
      rd(16'h0010, v);
      tests++; if (v !== 16'h1234) begin fails++; $display("FAIL ram_after_store: got %h want 1234", v); end
      for (int i = 0; i < 32; i++) begin
         a = 16'($urandom_range(0, 1023)); d = 16'($urandom);
         wr(a, d); model_mem[a] = d; written.push_back(int'(a));
      end
      foreach (written[i]) begin
         rd(16'(written[i]), v);
         tests++;
         if (v !== model_mem[written[i]]) begin
            fails++; $display("FAIL ram_rand @%h: got %h want %h", written[i], v, model_mem[written[i]]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         a = 16'(written[i]); d = 16'($urandom);
         ram_wen = 1'b1; ram_addr = a; ram_data = d; #1;
         tests++;
         if (ram_in !== model_mem[a]) begin fails++; $display("FAIL ram_old_data @%h: got %h want %h", a, ram_in, model_mem[a]); end
         @(posedge clk); #1; ram_wen = 1'b0; model_mem[a] = d;
         rd(a, v);
         tests++; if (v !== d) begin fails++; $display("FAIL ram_new_data @%h: got %h want %h", a, v, d); end
      end
   endtask

   task automatic test_unmapped;
      logic [15:0] v, a;
      logic [7:0]  g;
      wr(16'h0000, 16'h5A5A); model_mem[0] = 16'h5A5A;
      rd(16'h0400, v);
      tests++; if (v !== 16'h0000) begin fails++; $display("FAIL unmapped_0400: got %h want 0000", v); end
      rd(16'hFF07, v);
      tests++; if (v !== 16'h0000) begin fails++; $display("FAIL unmapped_ff07: got %h want 0000", v); end
      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom_range(16'h0400, 16'hFEFF));
         wr(a, 16'($urandom));
         rd(a, v);
         tests++; if (v !== 16'h0000) begin fails++; $display("FAIL unmapped_rand @%h: got %h want 0000", a, v); end
      end
      wr(16'h0400, 16'hDEAD);
      rd(16'h0000, v);
      tests++; if (v !== 16'h5A5A) begin fails++; $display("FAIL unmapped_alias: got %h want 5a5a", v); end
      g = gpio_out;
      for (int o = 5; o < 8; o++) begin
         wr(16'hFF00 + 16'(o), 16'hFFFF);
         rd(16'hFF00 + 16'(o), v);
         tests++; if (v !== 16'h0000) begin fails++; $display("FAIL mmio_reserved%0d: got %h want 0000", o, v); end
      end
      tests++; if (gpio_out !== g) begin fails++; $display("FAIL reserved_gpio: got %h want %h", gpio_out, g); end
   endtask

   task automatic test_gpio;
      logic [15:0] v, d;
      logic [7:0]  prev, nv;
      prev = gpio_in;
      for (int i = 0; i < 4; i++) begin
         nv = (i == 0) ? 8'hA5 : 8'($urandom);
         if (nv == prev) nv = ~prev;
         gpio_in = nv;
         for (int c = 0; c < 4; c++) begin
            rd(16'hFF01, v);
            tests++;
            if (v !== {8'h00, (c < 2 ? prev : nv)}) begin
               fails++; $display("FAIL gpio_in_sync c%0d: got %h want %h", c, v, {8'h00, (c < 2 ? prev : nv)});
            end
            @(posedge clk); #1;
         end
         prev = nv;
      end
      wr(16'hFF00, 16'h003C);
      tests++; if (gpio_out !== 8'h3C) begin fails++; $display("FAIL gpio_out_3c: got %h want 3c", gpio_out); end
      for (int i = 0; i < 4; i++) begin
         d = 16'($urandom);
         wr(16'hFF00, d);
         rd(16'hFF00, v);
         tests++;
         if (gpio_out !== d[7:0] || v !== {8'h00, d[7:0]}) begin
            fails++; $display("FAIL gpio_out_rand: got %h/%h want %h", gpio_out, v, d[7:0]);
         end
      end
      d = {8'h00, gpio_out};
      wr(16'hFF01, 16'($urandom));
      rd(16'hFF01, v);
      tests++;
      if (gpio_out !== d[7:0] || v !== {8'h00, prev}) begin
         fails++; $display("FAIL gpio_in_ro: got %h/%h want %h/%h", gpio_out, v, d[7:0], prev);
      end
   endtask

`ifdef ASCA_DMEM_TIMER_EN
   task automatic test_timer_reload;
      logic [15:0] v, c;
      rd(16'hFF02, v);
      tests++; if (v !== 16'h0000) begin fails++; $display("FAIL timer_frozen: got %h want 0000", v); end
      wr(16'hFF03, 16'd5);
      wr(16'hFF04, 16'h0003);
      for (int k = 0; k < 20; k++) begin
         rd(16'hFF02, v);
         rd(16'hFF04, c);
         tests++;
         if (v !== 16'(k % 6) || irq !== (k > 0 && k % 6 == 0) || c !== (k >= 6 ? 16'h0007 : 16'h0003)) begin
            fails++; $display("FAIL timer_reload k%0d: got cnt=%h irq=%b ctrl=%h want cnt=%h irq=%b", k, v, irq, c, 16'(k % 6), (k > 0 && k % 6 == 0));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timer_free;
      logic [15:0] v, c0, e;
      logic [15:0] starts [3];
      starts[0] = 16'd3; starts[1] = 16'hFFFA; starts[2] = 16'($urandom_range(16, 16'hFF00));
      wr(16'hFF04, 16'h0001);
      foreach (starts[s]) begin
         c0 = starts[s];
         wr(16'hFF02, c0);
         for (int k = 0; k < 12; k++) begin
            e = c0 + 16'(k);
            rd(16'hFF02, v);
            tests++; if (v !== e) begin fails++; $display("FAIL timer_free cnt: got %h want %h", v, e); end
            if (k > 0) begin
               tests++;
               if (irq !== (e - 16'd1 == 16'd5)) begin fails++; $display("FAIL timer_free irq at cnt %h: got %b", e, irq); end
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_tcmp_delay;
      logic [15:0] v, c;
      wr(16'hFF04, 16'h0007);
      wr(16'hFF02, 16'd100);
      wr(16'hFF03, 16'd100);
      rd(16'hFF02, v);
      rd(16'hFF04, c);
      tests++;
      if (irq !== 1'b0 || v !== 16'd101 || c !== 16'h0003) begin
         fails++; $display("FAIL tcmp_delay: got irq=%b cnt=%h ctrl=%h want 0/0065/0003", irq, v, c);
      end
   endtask

   task automatic test_w1c;
      logic [15:0] v, c;
      wr(16'hFF04, 16'h0000);
      wr(16'hFF03, 16'd10);
      wr(16'hFF02, 16'd8);
      wr(16'hFF04, 16'h0001);
      repeat (3) @(posedge clk); #1;
      rd(16'hFF02, v); rd(16'hFF04, c);
      tests++;
      if (irq !== 1'b1 || v !== 16'd11 || c !== 16'h0005) begin
         fails++; $display("FAIL match_set: got irq=%b cnt=%h ctrl=%h want 1/000b/0005", irq, v, c);
      end
      wr(16'hFF04, 16'h0005);
      rd(16'hFF04, c);
      tests++; if (c !== 16'h0001 || irq !== 1'b0) begin fails++; $display("FAIL w1c_clear: got ctrl=%h irq=%b want 0001/0", c, irq); end
      wr(16'hFF02, 16'd9);
      @(posedge clk); #1;
      wr(16'hFF04, 16'h0005);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL w1c_vs_hit irq: got %b want 1", irq); end
      rd(16'hFF04, c);
      tests++; if (c !== 16'h0005) begin fails++; $display("FAIL w1c_vs_hit ctrl: got %h want 0005", c); end
   endtask
`else
   task automatic test_no_timer;
      logic [15:0] v;
      wr(16'hFF04, 16'h0003);
      for (int o = 2; o < 5; o++) begin
         wr(16'hFF00 + 16'(o), 16'($urandom) | 16'h0001);
         rd(16'hFF00 + 16'(o), v);
         tests++; if (v !== 16'h0000) begin fails++; $display("FAIL no_timer_reg%0d: got %h want 0000", o, v); end
      end
      wr(16'hFF03, 16'h0000);
      wr(16'hFF04, 16'h0003);
      for (int k = 0; k < 40; k++) begin
         tests++; if (irq !== 1'b0) begin fails++; $display("FAIL no_timer_irq k%0d: got %b want 0", k, irq); end
         @(posedge clk); #1;
      end
   endtask
`endif

   task automatic test_reset_mid;
      logic [15:0] v;
      logic [15:0] exp_cmp;
      exp_cmp = TIMER ? 16'hFFFF : 16'h0000;
      #1 reset = 1'b1; #1;
      tests++; if (irq !== 1'b0 || gpio_out !== 8'h00) begin fails++; $display("FAIL reset_async: got irq=%b gpio=%h want 0/00", irq, gpio_out); end
      rd(16'hFF02, v);
      tests++; if (v !== 16'h0000) begin fails++; $display("FAIL reset_tcnt: got %h want 0000", v); end
      rd(16'hFF03, v);
      tests++; if (v !== exp_cmp) begin fails++; $display("FAIL reset_tcmp: got %h want %h", v, exp_cmp); end
      rd(16'hFF04, v);
      tests++; if (v !== 16'h0000) begin fails++; $display("FAIL reset_tctrl: got %h want 0000", v); end
      rd(16'hFF01, v);
      tests++; if (v !== 16'h0000) begin fails++; $display("FAIL reset_sync: got %h want 0000", v); end
      wr(16'h0020, 16'h2222);
      reset = 1'b0;
      rd(16'h0020, v);
      tests++; if (v !== model_mem[32]) begin fails++; $display("FAIL reset_store_lost: got %h want %h", v, model_mem[32]); end
      rd(16'h0010, v);
      tests++; if (v !== model_mem[16]) begin fails++; $display("FAIL reset_ram_kept: got %h want %h", v, model_mem[16]); end
      repeat (3) @(posedge clk); #1;
      rd(16'hFF02, v);
      tests++; if (v !== 16'h0000 || irq !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got cnt=%h irq=%b", v, irq); end
   endtask

   initial begin
      reset = 1'b1; ram_wen = 1'b0; ram_addr = '0; ram_data = '0; gpio_in = 8'h00;
      repeat (2) @(posedge clk); #1;
      test_reset;
      test_ram;
      test_unmapped;
      test_gpio;
`ifdef ASCA_DMEM_TIMER_EN
      test_timer_reload;
      test_timer_free;
      test_tcmp_delay;
      test_w1c;
`else
      test_no_timer;
`endif
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
